// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_ctrl #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 8,
  parameter int AFULL_LVL  = (1 << ASIZE) - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE + 1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE + 1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE:0]   wptr_q, rptr_q, count_q, count_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic             ovf_d, unf_d;
  logic             wr_ok, rd_ok;

  // A read frees a slot on the same edge, so a full FIFO can still accept a write.
  assign rd_ok = rinc & ~rempty_q;
  assign wr_ok = winc & (~wfull_q | rd_ok);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Setting wins over clearing so an error in the clear cycle is never lost.
    ovf_d = (winc & ~wr_ok) | (ovf_q & ~clr_err);
    unf_d = (rinc & ~rd_ok) | (unf_q & ~clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      count_q  <= count_d;
      wfull_q  <= (count_d == DEPTH_C);
      rempty_q <= (count_d == '0);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: storage has no reset; only pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem_q[rptr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (rd_ok) rdata_q <= mem_q[rptr_q[ASIZE-1:0]];
  end

  assign rdata = rdata_q;
`endif

  assign count         = count_q;
  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule
